id_ex_reg: RTL and testbench
============================

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter: DATA_W, 32, width of operand and immediate data fields.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RESET  in  1  reset, synchronous, active-high.
REQ-004 StallE  in  1  hold all E-stage contents this cycle.
REQ-005 FlushE  in  1  replace E-stage contents with a bubble this cycle.
REQ-006 ValidD  in  1  decode-stage instruction valid.
REQ-007 PCSD, RegWD, MemWD, BD, MemtoRegD, ALUSrcD  in  1 each  decode control bits.
REQ-008 FlagWD  in  2  decode flag-write enables.
REQ-009 CondD  in  4  decode condition field.
REQ-010 ALUControlD  in  2  decode ALU operation select.
REQ-011 RD1D, RD2D, ExtImmD  in  DATA_W each  decode operands and extended immediate.
REQ-012 WA3D, RA1D, RA2D  in  4 each  destination and source register numbers.
REQ-013 ValidE, PCSE, RegWE, MemWE, BE, MemtoRegE, ALUSrcE  out  1 each  registered copies.
REQ-014 FlagWE  out  2; CondE  out  4; ALUControlE  out  2  registered copies.
REQ-015 RD1E, RD2E, ExtImmE  out  DATA_W; WA3E, RA1E, RA2E  out  4  registered copies.
REQ-016 BubbleCnt  out  8  saturating count of bubbles inserted by FlushE.

Function
REQ-017 All outputs SHALL be driven directly from flops; no combinational input-to-output path.
REQ-018 Per-edge priority SHALL be: RESET > FlushE > StallE > load.
REQ-019 Load (no RESET, FlushE=0, StallE=0): every E output SHALL take its D input at the edge; latency exactly 1 cycle.
REQ-020 Stall (StallE=1, FlushE=0): every E output and BubbleCnt SHALL hold its value.
REQ-021 Flush (FlushE=1): ValidE, PCSE, RegWE, MemWE, BE, MemtoRegE, ALUSrcE SHALL become 0; FlagWE=2'b00; ALUControlE=2'b00; CondE=4'b1110; all data and register-number fields SHALL become 0.
REQ-022 FlushE=1 with StallE=1 SHALL produce the bubble of REQ-021 (flush wins).
REQ-023 Load with ValidD=0 SHALL load fields as in REQ-019, but PCSE, RegWE, MemWE, BE and FlagWE SHALL be forced to 0, so no architectural write can occur.
REQ-024 BubbleCnt SHALL increment by 1 on each edge where FlushE=1 and RESET=0, saturating at 8'hFF (no wrap).
REQ-025 BubbleCnt SHALL NOT change on load or stall edges.
REQ-026 Inputs SHALL be sampled only at the rising edge; changes between edges SHALL have no effect.

Reset
REQ-027 RESET=1 at an edge SHALL set all outputs to the bubble values of REQ-021 and BubbleCnt=0, regardless of StallE/FlushE.
REQ-028 RESET asserted mid-stall or mid-flush SHALL take effect at that same edge; the first edge after deassertion SHALL behave per REQ-018..REQ-025.

Verification
REQ-029 RESET 1 cycle, then idle -> all outputs 0 except CondE=4'b1110; BubbleCnt=0.
REQ-030 Load ValidD=1, RegWD=1, CondD=4'b0000, RD1D=32'h1234_5678, WA3D=4'd7 -> next cycle RegWE=1, CondE=0, RD1E=32'h1234_5678, WA3E=7, ValidE=1.
REQ-031 After REQ-030, StallE=1 for 3 cycles with D inputs changed -> E outputs unchanged all 3 cycles; BubbleCnt unchanged.
REQ-032 FlushE=1 and StallE=1 together with MemWD=1 -> next cycle MemWE=0, ValidE=0, CondE=4'b1110, BubbleCnt increments by 1.
REQ-033 FlushE held 260 cycles -> BubbleCnt reaches 8'hFF and stays 8'hFF.
REQ-034 Load ValidD=0, PCSD=1, MemWD=1, FlagWD=2'b11, RD2D=32'hFFFF_FFFF -> PCSE=0, MemWE=0, FlagWE=0, ValidE=0, RD2E=32'hFFFF_FFFF.

Source files
------------

// File: rtl/id_ex_reg.sv
// Decode-to-execute pipeline register with stall, flush-to-bubble and a saturating
// count of inserted bubbles. Every output comes straight from a flop.
module id_ex_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic              PCSD,
  input  logic              RegWD,
  input  logic              MemWD,
  input  logic              BD,
  input  logic              MemtoRegD,
  input  logic              ALUSrcD,
  input  logic [1:0]        FlagWD,
  input  logic [3:0]        CondD,
  input  logic [1:0]        ALUControlD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [3:0]        WA3D,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  output logic              ValidE,
  output logic              PCSE,
  output logic              RegWE,
  output logic              MemWE,
  output logic              BE,
  output logic              MemtoRegE,
  output logic              ALUSrcE,
  output logic [1:0]        FlagWE,
  output logic [3:0]        CondE,
  output logic [1:0]        ALUControlE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [3:0]        WA3E,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [7:0]        BubbleCnt
);

  // A bubble carries the "always" condition so downstream condition logic stays benign.
  localparam logic [3:0] CondAlways = 4'b1110;
  localparam logic [7:0] CntMax     = 8'hFF;

  logic              r_valid;
  logic              r_pcs;
  logic              r_regw;
  logic              r_memw;
  logic              r_b;
  logic              r_memtoreg;
  logic              r_alusrc;
  logic [1:0]        r_flagw;
  logic [3:0]        r_cond;
  logic [1:0]        r_aluctl;
  logic [DATA_W-1:0] r_rd1;
  logic [DATA_W-1:0] r_rd2;
  logic [DATA_W-1:0] r_extimm;
  logic [3:0]        r_wa3;
  logic [3:0]        r_ra1;
  logic [3:0]        r_ra2;
  logic [7:0]        r_bubble_cnt;

  logic w_bubble;
  logic w_load;
  logic w_cnt_inc;

  always_comb begin
    w_bubble  = RESET | FlushE;
    w_load    = ~w_bubble & ~StallE;
    w_cnt_inc = ~RESET & FlushE & (r_bubble_cnt != CntMax);
  end

  // Architectural write enables are gated by ValidD so an invalid slot can never commit.
  always_ff @(posedge CLK) begin
    if (w_bubble) begin
      r_valid    <= 1'b0;
      r_pcs      <= 1'b0;
      r_regw     <= 1'b0;
      r_memw     <= 1'b0;
      r_b        <= 1'b0;
      r_memtoreg <= 1'b0;
      r_alusrc   <= 1'b0;
      r_flagw    <= 2'b00;
      r_cond     <= CondAlways;
      r_aluctl   <= 2'b00;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_extimm   <= '0;
      r_wa3      <= 4'd0;
      r_ra1      <= 4'd0;
      r_ra2      <= 4'd0;
    end else if (w_load) begin
      r_valid    <= ValidD;
      r_pcs      <= PCSD & ValidD;
      r_regw     <= RegWD & ValidD;
      r_memw     <= MemWD & ValidD;
      r_b        <= BD & ValidD;
      r_memtoreg <= MemtoRegD;
      r_alusrc   <= ALUSrcD;
      r_flagw    <= FlagWD & {2{ValidD}};
      r_cond     <= CondD;
      r_aluctl   <= ALUControlD;
      r_rd1      <= RD1D;
      r_rd2      <= RD2D;
      r_extimm   <= ExtImmD;
      r_wa3      <= WA3D;
      r_ra1      <= RA1D;
      r_ra2      <= RA2D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_bubble_cnt <= 8'd0;
    end else if (w_cnt_inc) begin
      r_bubble_cnt <= r_bubble_cnt + 8'd1;
    end
  end

  assign ValidE      = r_valid;
  assign PCSE        = r_pcs;
  assign RegWE       = r_regw;
  assign MemWE       = r_memw;
  assign BE          = r_b;
  assign MemtoRegE   = r_memtoreg;
  assign ALUSrcE     = r_alusrc;
  assign FlagWE      = r_flagw;
  assign CondE       = r_cond;
  assign ALUControlE = r_aluctl;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign ExtImmE     = r_extimm;
  assign WA3E        = r_wa3;
  assign RA1E        = r_ra1;
  assign RA2E        = r_ra2;
  assign BubbleCnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: directed scenarios followed by randomized
// reset/flush/stall/load traffic compared against a behavioural model.
module tb_id_ex_reg;

  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET, StallE, FlushE, ValidD;
  logic          PCSD, RegWD, MemWD, BD, MemtoRegD, ALUSrcD;
  logic [1:0]    FlagWD, ALUControlD;
  logic [3:0]    CondD, WA3D, RA1D, RA2D;
  logic [DW-1:0] RD1D, RD2D, ExtImmD;

  logic          ValidE, PCSE, RegWE, MemWE, BE, MemtoRegE, ALUSrcE;
  logic [1:0]    FlagWE, ALUControlE;
  logic [3:0]    CondE, WA3E, RA1E, RA2E;
  logic [DW-1:0] RD1E, RD2E, ExtImmE;
  logic [7:0]    BubbleCnt;

  // Reference state: what the E stage should hold
  logic          m_valid, m_pcs, m_regw, m_memw, m_b, m_mtr, m_alusrc;
  logic [1:0]    m_flagw, m_aluctl;
  logic [3:0]    m_cond, m_wa3, m_ra1, m_ra2;
  logic [DW-1:0] m_rd1, m_rd2, m_imm;
  int            m_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_before;

  always #5 CLK = ~CLK;

  id_ex_reg #(.DATA_W(DW)) dut (
    .CLK(CLK), .RESET(RESET), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .PCSD(PCSD), .RegWD(RegWD), .MemWD(MemWD), .BD(BD), .MemtoRegD(MemtoRegD),
    .ALUSrcD(ALUSrcD), .FlagWD(FlagWD), .CondD(CondD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .WA3D(WA3D), .RA1D(RA1D), .RA2D(RA2D),
    .ValidE(ValidE), .PCSE(PCSE), .RegWE(RegWE), .MemWE(MemWE), .BE(BE),
    .MemtoRegE(MemtoRegE), .ALUSrcE(ALUSrcE), .FlagWE(FlagWE), .CondE(CondE),
    .ALUControlE(ALUControlE), .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE),
    .WA3E(WA3E), .RA1E(RA1E), .RA2E(RA2E), .BubbleCnt(BubbleCnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".ValidE"},      64'(ValidE),      64'(m_valid));
    chk({ctx, ".PCSE"},        64'(PCSE),        64'(m_pcs));
    chk({ctx, ".RegWE"},       64'(RegWE),       64'(m_regw));
    chk({ctx, ".MemWE"},       64'(MemWE),       64'(m_memw));
    chk({ctx, ".BE"},          64'(BE),          64'(m_b));
    chk({ctx, ".MemtoRegE"},   64'(MemtoRegE),   64'(m_mtr));
    chk({ctx, ".ALUSrcE"},     64'(ALUSrcE),     64'(m_alusrc));
    chk({ctx, ".FlagWE"},      64'(FlagWE),      64'(m_flagw));
    chk({ctx, ".CondE"},       64'(CondE),       64'(m_cond));
    chk({ctx, ".ALUControlE"}, 64'(ALUControlE), 64'(m_aluctl));
    chk({ctx, ".RD1E"},        64'(RD1E),        64'(m_rd1));
    chk({ctx, ".RD2E"},        64'(RD2E),        64'(m_rd2));
    chk({ctx, ".ExtImmE"},     64'(ExtImmE),     64'(m_imm));
    chk({ctx, ".WA3E"},        64'(WA3E),        64'(m_wa3));
    chk({ctx, ".RA1E"},        64'(RA1E),        64'(m_ra1));
    chk({ctx, ".RA2E"},        64'(RA2E),        64'(m_ra2));
    chk({ctx, ".BubbleCnt"},   64'(BubbleCnt),   64'(m_cnt));
  endtask

  task automatic model_bubble();
    {m_valid, m_pcs, m_regw, m_memw, m_b, m_mtr, m_alusrc} = '0;
    m_flagw = 2'b00; m_aluctl = 2'b00; m_cond = 4'b1110;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_wa3 = '0; m_ra1 = '0; m_ra2 = '0;
  endtask

  // Applies the edge rules in priority order: reset, flush, stall, load
  task automatic model_edge();
    if (RESET) begin
      model_bubble();
      m_cnt = 0;
    end else if (FlushE) begin
      model_bubble();
      m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end else if (!StallE) begin
      m_valid  = ValidD;
      m_pcs    = ValidD ? PCSD : 1'b0;
      m_regw   = ValidD ? RegWD : 1'b0;
      m_memw   = ValidD ? MemWD : 1'b0;
      m_b      = ValidD ? BD : 1'b0;
      m_flagw  = ValidD ? FlagWD : 2'b00;
      m_mtr    = MemtoRegD;
      m_alusrc = ALUSrcD;
      m_cond   = CondD;
      m_aluctl = ALUControlD;
      m_rd1 = RD1D; m_rd2 = RD2D; m_imm = ExtImmD;
      m_wa3 = WA3D; m_ra1 = RA1D; m_ra2 = RA2D;
    end
  endtask

  task automatic step(input string ctx);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(ctx);
  endtask

  task automatic idle_d();
    {ValidD, PCSD, RegWD, MemWD, BD, MemtoRegD, ALUSrcD} = '0;
    FlagWD = '0; ALUControlD = '0; CondD = 4'b1110;
    RD1D = '0; RD2D = '0; ExtImmD = '0; WA3D = '0; RA1D = '0; RA2D = '0;
  endtask

  task automatic rand_d();
    {ValidD, PCSD, RegWD, MemWD, BD, MemtoRegD, ALUSrcD} = 7'($urandom);
    FlagWD = 2'($urandom); ALUControlD = 2'($urandom); CondD = 4'($urandom);
    RD1D = $urandom; RD2D = $urandom; ExtImmD = $urandom;
    WA3D = 4'($urandom); RA1D = 4'($urandom); RA2D = 4'($urandom);
  endtask

  initial begin
    RESET = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    idle_d();
    m_cnt = 0;
    model_bubble();

    // Reset state, then an idle edge that reloads the same bubble-like values
    step("reset");
    chk("reset.CondE_const", 64'(CondE), 64'hE);
    chk("reset.Cnt_const", 64'(BubbleCnt), 64'h0);
    RESET = 1'b0;
    step("idle");

    // Basic load
    ValidD = 1'b1; RegWD = 1'b1; CondD = 4'b0000; RD1D = 32'h1234_5678; WA3D = 4'd7;
    step("load");
    chk("load.RegWE_const", 64'(RegWE), 64'h1);
    chk("load.RD1E_const", 64'(RD1E), 64'h1234_5678);
    chk("load.WA3E_const", 64'(WA3E), 64'h7);
    chk("load.ValidE_const", 64'(ValidE), 64'h1);

    // Stall holds everything while D changes
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_d();
      step("stall");
      chk("stall.RD1E_const", 64'(RD1E), 64'h1234_5678);
    end

    // Flush wins over stall
    cnt_before = int'(BubbleCnt);
    FlushE = 1'b1; ValidD = 1'b1; MemWD = 1'b1;
    step("flush_stall");
    chk("flush_stall.MemWE_const", 64'(MemWE), 64'h0);
    chk("flush_stall.cnt_inc", 64'(BubbleCnt), 64'(cnt_before + 1));
    StallE = 1'b0;

    // Long flush saturates the counter
    for (int i = 0; i < 260; i++) begin
      rand_d();
      step("flush_long");
    end
    chk("flush_long.sat", 64'(BubbleCnt), 64'hFF);
    FlushE = 1'b0;

    // Invalid slot suppresses write enables but keeps data
    idle_d();
    PCSD = 1'b1; MemWD = 1'b1; FlagWD = 2'b11; RD2D = 32'hFFFF_FFFF;
    step("invalid");
    chk("invalid.PCSE_const", 64'(PCSE), 64'h0);
    chk("invalid.FlagWE_const", 64'(FlagWE), 64'h0);
    chk("invalid.RD2E_const", 64'(RD2E), 64'hFFFF_FFFF);

    // Reset in the middle of a stall clears the counter at that edge
    StallE = 1'b1; RESET = 1'b1; rand_d();
    step("reset_stall");
    chk("reset_stall.cnt_const", 64'(BubbleCnt), 64'h0);
    RESET = 1'b0; StallE = 1'b0;

    // Random traffic; mid-cycle input changes must not reach the outputs
    for (int i = 0; i < 400; i++) begin
      rand_d();
      RESET  = ($urandom_range(0, 99) < 3);
      FlushE = ($urandom_range(0, 99) < 15);
      StallE = ($urandom_range(0, 99) < 25);
      step("rand");
      rand_d();
      RESET = 1'($urandom); FlushE = 1'($urandom); StallE = 1'($urandom);
      #2;
      check_all("rand_mid");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
